mbinit_repairmb_partner_p: RTL
==============================

Name: mbinit_repairmb_partner_p

Overview:
- Partner-side (responder) FSM for the MBINIT.REPAIRMB sideband step, sitting between the RX sideband decoder, the TX sideband arbiter and the width-degrade/repeater logic.
- Generalised over message width, lane-group count and number of degrade/repeat rounds.
- Adds a timeout watchdog and a sticky error state; lane-map checking is built in.

Parameters:
- MSG_W, 4, sideband message-code width.
- LANE_GRP, 2, functional lane-group bitmap width; must be even and ≥2.
- MAX_ROUNDS, 2, repeater rounds allowed before train error.
- TIMEOUT_CYCLES, 8000, watchdog limit; 0 disables the watchdog.
- TO_W, 16, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_MBINIT_REVERSALMB_end  in  1  step enable, level; low aborts to IDLE
- i_Busy_SideBand  in  1  TX sideband busy
- i_falling_edge_busy  in  1  one-cycle pulse: TX sideband finished sending
- i_RX_SbMessage  in  MSG_W  received message code
- i_msg_valid  in  1  i_RX_SbMessage valid this cycle
- i_Functional_Lanes  in  LANE_GRP  partner lane map from msginfo; bit k = group k good
- i_Done_Repeater  in  1  pulse: local TX repeat finished
- i_Transmitter_initiated_Data_to_CLK_en  in  1  high = defer degrade requests
- o_Start_Repeater  out  1  one-cycle pulse
- o_apply_repeater  out  1  level, high from repeat decision until APPLY_REPEAT entry
- o_TX_SbMessage  out  MSG_W  response code
- o_ValidOutDatat_REPAIRMB_Module_Partner  out  1  response valid
- o_Functional_Lanes  out  LANE_GRP  applied RX width
- o_degrade_round  out  $clog2(MAX_ROUNDS+1)  repeats done
- o_train_error  out  1  sticky error
- o_MBINIT_REPAIRMB_Module_Partner_end  out  1  step done, level

Behaviour:
- Reset values: o_Functional_Lanes = all ones; all other outputs 0.
- Register style: outputs are registered and decoded from NS, so they align with CS.
- States and transitions:
  - IDLE → WAIT_START on enable.
  - WAIT_START → BUSY_START on start_req & valid.
  - BUSY_START → START_RESP when ~busy.
  - START_RESP → HANDLE on i_falling_edge_busy.
  - HANDLE:
    - apply_degrade_req & valid & ~Data_to_CLK_en → CHECK, capturing the lane map into lane_q.
    - end_req & valid & cont → BUSY_END.
  - CHECK (exactly 1 cycle) evaluates lane_q:
    - Illegal → ERROR. Illegal means zero, or not one of {all ones, lower half ones only, upper half ones only}.
    - All ones, or lane_q == o_Functional_Lanes with round>0 → set cont; go to BUSY_DEG.
    - Otherwise degrade needed: if round == MAX_ROUNDS → ERROR; else load o_Functional_Lanes ← lane_q, raise o_apply_repeater, clear cont, go to APPLY_REPEAT.
  - APPLY_REPEAT:
    - On entry: o_Start_Repeater pulses once, o_apply_repeater drops, round increments.
    - → HANDLE on i_Done_Repeater.
  - BUSY_DEG → DEG_RESP when ~busy; DEG_RESP → HANDLE on falling edge.
  - BUSY_END → END_RESP when ~busy; END_RESP → DONE on falling edge.
  - DONE: end output high while enable stays high.
  - ERROR: o_train_error high while enable stays high.
- Responses: o_ValidOut=1 with code start_resp / apply_degrade_resp / end_resp on every cycle CS is START_RESP / DEG_RESP / END_RESP; otherwise code 0, valid 0.
- Ignored inputs:
  - end_req while cont=0.
  - Any other code or invalid message.
  - Degrade request while Data_to_CLK_en=1; this is deferred, so the partner must resend.
- Watchdog:
  - Counter clears on every state change and counts in all states except IDLE/DONE/ERROR.
  - Reaching TIMEOUT_CYCLES-1 → ERROR next cycle.
- Enable low in any state → IDLE next cycle. This clears cont, round, error, end, valid, o_apply_repeater and the watchdog. o_Functional_Lanes is retained.
- IDLE→WAIT_START reloads o_Functional_Lanes to all ones.
- Priority, highest first: enable drop > watchdog > message handling. In HANDLE, a degrade request beats end_req.
- i_Done_Repeater outside APPLY_REPEAT is ignored.

Decomposition:
- Package mbinit_pkg holds:
  - message codes: start_req=1, start_resp=2, end_req=3, end_resp=4, apply_degrade_req=5, apply_degrade_resp=6;
  - the state enum;
  - the lane-map legality function.
- One sub-module, mbinit_lane_map_checker: combinational legal / full / same-as-applied flags from lane_q, o_Functional_Lanes and round.

Test Plan:
- Happy path:
  - Stimulus: enable; start_req; degrade_req with map 2'b11; end_req.
  - Required: codes 2, 6, 4 emitted in order; end output high; o_Functional_Lanes=11; round=0.
- One degrade round:
  - Stimulus: degrade_req map 01.
  - Required: o_apply_repeater then a single o_Start_Repeater pulse; lanes=01.
  - Then: Done_Repeater, degrade_req 01 → resp 6 with round=1; end_req → end output high.
- Round exhaustion: MAX_ROUNDS=2 with maps 01, 10, 01 → two repeats, then o_train_error=1 with no response sent.
- Illegal map and deferral:
  - Map 00 → ERROR.
  - Map 11 sent while Data_to_CLK_en=1 → stays in HANDLE; the same request after the enable drops is accepted.
- Watchdog: TIMEOUT_CYCLES=16 and no start_req → o_train_error rises 16 cycles after WAIT_START entry; enable low clears it.
- Abort mid-response: drop enable during DEG_RESP → valid goes 0 next cycle, FSM in IDLE, cont cleared; a restart completes normally.

Source files
------------

// File: rtl/mbinit_repairmb_partner_p_pkg.sv
// Shared message codes, FSM state encoding and lane-map legality for the
// MBINIT.REPAIRMB partner responder.
package mbinit_pkg;

  localparam int MSG_START_REQ   = 1;
  localparam int MSG_START_RESP  = 2;
  localparam int MSG_END_REQ     = 3;
  localparam int MSG_END_RESP    = 4;
  localparam int MSG_DEGRADE_REQ = 5;
  localparam int MSG_DEGRADE_RSP = 6;

  // Widest lane-group bitmap the legality helper understands.
  localparam int LANE_MAX = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_BUSY_START,
    ST_START_RESP,
    ST_HANDLE,
    ST_CHECK,
    ST_APPLY_REPEAT,
    ST_BUSY_DEG,
    ST_DEG_RESP,
    ST_BUSY_END,
    ST_END_RESP,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Legal maps: all groups, lower half only, or upper half only.
  function automatic logic lane_map_legal(input logic [LANE_MAX-1:0] map,
                                          input int width);
    logic [LANE_MAX-1:0] full;
    logic [LANE_MAX-1:0] lo;
    logic [LANE_MAX-1:0] hi;
    full = (width >= LANE_MAX) ? '1 : ((LANE_MAX'(1) << width) - LANE_MAX'(1));
    lo   = (LANE_MAX'(1) << (width / 2)) - LANE_MAX'(1);
    hi   = full & ~lo;
    return (map != '0) && ((map == full) || (map == lo) || (map == hi));
  endfunction

endpackage

// File: rtl/mbinit_repairmb_partner_p_if.sv
// Sideband-facing bundle of the REPAIRMB partner: RX decode, TX arbiter and
// repeater handshakes. The partner FSM uses the slave view.
interface mbinit_sb_if #(
  parameter int MSG_W    = 4,
  parameter int LANE_GRP = 2,
  parameter int ROUND_W  = 2
);
  logic                i_MBINIT_REVERSALMB_end;
  logic                i_Busy_SideBand;
  logic                i_falling_edge_busy;
  logic [MSG_W-1:0]    i_RX_SbMessage;
  logic                i_msg_valid;
  logic [LANE_GRP-1:0] i_Functional_Lanes;
  logic                i_Done_Repeater;
  logic                i_Transmitter_initiated_Data_to_CLK_en;

  logic                o_Start_Repeater;
  logic                o_apply_repeater;
  logic [MSG_W-1:0]    o_TX_SbMessage;
  logic                o_ValidOutDatat_REPAIRMB_Module_Partner;
  logic [LANE_GRP-1:0] o_Functional_Lanes;
  logic [ROUND_W-1:0]  o_degrade_round;
  logic                o_train_error;
  logic                o_MBINIT_REPAIRMB_Module_Partner_end;

  modport slave (
    input  i_MBINIT_REVERSALMB_end, i_Busy_SideBand, i_falling_edge_busy,
           i_RX_SbMessage, i_msg_valid, i_Functional_Lanes, i_Done_Repeater,
           i_Transmitter_initiated_Data_to_CLK_en,
    output o_Start_Repeater, o_apply_repeater, o_TX_SbMessage,
           o_ValidOutDatat_REPAIRMB_Module_Partner, o_Functional_Lanes,
           o_degrade_round, o_train_error, o_MBINIT_REPAIRMB_Module_Partner_end
  );

  modport master (
    output i_MBINIT_REVERSALMB_end, i_Busy_SideBand, i_falling_edge_busy,
           i_RX_SbMessage, i_msg_valid, i_Functional_Lanes, i_Done_Repeater,
           i_Transmitter_initiated_Data_to_CLK_en,
    input  o_Start_Repeater, o_apply_repeater, o_TX_SbMessage,
           o_ValidOutDatat_REPAIRMB_Module_Partner, o_Functional_Lanes,
           o_degrade_round, o_train_error, o_MBINIT_REPAIRMB_Module_Partner_end
  );
endinterface

// File: rtl/mbinit_repairmb_partner_p_lane_map_checker.sv
// Combinational evaluation of a captured partner lane map against the
// currently applied RX width.
module mbinit_lane_map_checker
  import mbinit_pkg::*;
#(
  parameter int LANE_GRP = 2,
  parameter int ROUND_W  = 2
) (
  input  logic [LANE_GRP-1:0] lane_i,
  input  logic [LANE_GRP-1:0] applied_i,
  input  logic [ROUND_W-1:0]  round_i,
  output logic                legal_o,
  output logic                full_o,
  output logic                same_o
);

  assign legal_o = lane_map_legal(LANE_MAX'(lane_i), LANE_GRP);
  assign full_o  = &lane_i;
  // A repeat of the already-applied map only counts once a repeat has run.
  assign same_o  = (lane_i == applied_i) && (round_i != '0);

endmodule

// File: rtl/mbinit_repairmb_partner_p.sv
// Partner-side responder FSM for MBINIT.REPAIRMB with width degrade,
// bounded repeater rounds, a watchdog and a sticky error state.
//
// state        | meaning
// -------------+-----------------------------------------------------
// IDLE         | step disabled, waiting for enable
// WAIT_START   | waiting for start_req
// BUSY_START   | start_resp queued, waiting for TX sideband idle
// START_RESP   | sending start_resp until TX finishes
// HANDLE       | waiting for degrade_req or end_req
// CHECK        | one-cycle evaluation of the captured lane map
// APPLY_REPEAT | repeater kicked, waiting for local repeat done
// BUSY_DEG     | degrade_resp queued, waiting for TX sideband idle
// DEG_RESP     | sending degrade_resp until TX finishes
// BUSY_END     | end_resp queued, waiting for TX sideband idle
// END_RESP     | sending end_resp until TX finishes
// DONE         | step complete, end output held
// ERROR        | sticky training error, held until enable drops
module mbinit_repairmb_partner_p
  import mbinit_pkg::*;
#(
  parameter int MSG_W          = 4,
  parameter int LANE_GRP       = 2,
  parameter int MAX_ROUNDS     = 2,
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int TO_W           = 16
) (
  input logic     CLK,
  input logic     rst_n,
  mbinit_sb_if.slave sb
);

  localparam int ROUND_W = $clog2(MAX_ROUNDS + 1);
  localparam bit WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LOAD = WD_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e              cs_q, ns;
  logic [LANE_GRP-1:0] lane_q, lane_d;
  logic [LANE_GRP-1:0] lanes_q, lanes_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic                cont_q, cont_d;
  logic                apply_q, apply_d;
  logic                start_rep_q, start_rep_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [MSG_W-1:0]    tx_msg_q, tx_msg_d;
  logic                valid_q, valid_d;
  logic                end_q, end_d;
  logic                err_q, err_d;

  logic map_legal, map_full, map_same;
  logic counting, timeout;
  logic msg_start, msg_end, msg_deg;

  mbinit_lane_map_checker #(
    .LANE_GRP (LANE_GRP),
    .ROUND_W  (ROUND_W)
  ) u_checker (
    .lane_i    (lane_q),
    .applied_i (lanes_q),
    .round_i   (round_q),
    .legal_o   (map_legal),
    .full_o    (map_full),
    .same_o    (map_same)
  );

  assign msg_start = sb.i_msg_valid && (sb.i_RX_SbMessage == MSG_W'(MSG_START_REQ));
  assign msg_end   = sb.i_msg_valid && (sb.i_RX_SbMessage == MSG_W'(MSG_END_REQ));
  assign msg_deg   = sb.i_msg_valid && (sb.i_RX_SbMessage == MSG_W'(MSG_DEGRADE_REQ));

  // Watchdog is a down-counter reloaded on every state change.
  assign counting = !(cs_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign timeout  = WD_EN && counting && (cnt_q == '0);

  always_comb begin
    ns          = cs_q;
    lane_d      = lane_q;
    lanes_d     = lanes_q;
    round_d     = round_q;
    cont_d      = cont_q;
    apply_d     = apply_q;
    start_rep_d = 1'b0;

    if (!sb.i_MBINIT_REVERSALMB_end) begin
      ns      = ST_IDLE;
      cont_d  = 1'b0;
      round_d = '0;
      apply_d = 1'b0;
    end else if (timeout) begin
      ns = ST_ERROR;
    end else begin
      unique case (cs_q)
        ST_IDLE: begin
          ns      = ST_WAIT_START;
          lanes_d = '1;
          cont_d  = 1'b0;
          round_d = '0;
        end
        ST_WAIT_START: if (msg_start) ns = ST_BUSY_START;
        ST_BUSY_START: if (!sb.i_Busy_SideBand) ns = ST_START_RESP;
        ST_START_RESP: if (sb.i_falling_edge_busy) ns = ST_HANDLE;
        ST_HANDLE: begin
          if (msg_deg && !sb.i_Transmitter_initiated_Data_to_CLK_en) begin
            ns     = ST_CHECK;
            lane_d = sb.i_Functional_Lanes;
          end else if (msg_end && cont_q) begin
            ns = ST_BUSY_END;
          end
        end
        ST_CHECK: begin
          if (!map_legal) begin
            ns = ST_ERROR;
          end else if (map_full || map_same) begin
            cont_d = 1'b1;
            ns     = ST_BUSY_DEG;
          end else if (round_q == ROUND_W'(MAX_ROUNDS)) begin
            ns = ST_ERROR;
          end else begin
            lanes_d = lane_q;
            apply_d = 1'b1;
            cont_d  = 1'b0;
            ns      = ST_APPLY_REPEAT;
          end
        end
        ST_APPLY_REPEAT: begin
          // First cycle here converts the apply request into the start pulse.
          if (apply_q) begin
            start_rep_d = 1'b1;
            apply_d     = 1'b0;
            round_d     = round_q + ROUND_W'(1);
          end else if (sb.i_Done_Repeater) begin
            ns = ST_HANDLE;
          end
        end
        ST_BUSY_DEG:  if (!sb.i_Busy_SideBand) ns = ST_DEG_RESP;
        ST_DEG_RESP:  if (sb.i_falling_edge_busy) ns = ST_HANDLE;
        ST_BUSY_END:  if (!sb.i_Busy_SideBand) ns = ST_END_RESP;
        ST_END_RESP:  if (sb.i_falling_edge_busy) ns = ST_DONE;
        default: ;
      endcase
    end

    if (ns != cs_q)     cnt_d = TO_LOAD;
    else if (timeout)   cnt_d = cnt_q;
    else if (counting)  cnt_d = cnt_q - TO_W'(1);
    else                cnt_d = cnt_q;

    tx_msg_d = '0;
    valid_d  = 1'b0;
    unique case (ns)
      ST_START_RESP: begin tx_msg_d = MSG_W'(MSG_START_RESP);  valid_d = 1'b1; end
      ST_DEG_RESP:   begin tx_msg_d = MSG_W'(MSG_DEGRADE_RSP); valid_d = 1'b1; end
      ST_END_RESP:   begin tx_msg_d = MSG_W'(MSG_END_RESP);    valid_d = 1'b1; end
      default: ;
    endcase
    end_d = (ns == ST_DONE);
    err_d = (ns == ST_ERROR);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cs_q        <= ST_IDLE;
      lane_q      <= '0;
      lanes_q     <= '1;
      round_q     <= '0;
      cont_q      <= 1'b0;
      apply_q     <= 1'b0;
      start_rep_q <= 1'b0;
      cnt_q       <= TO_LOAD;
      tx_msg_q    <= '0;
      valid_q     <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_q        <= ns;
      lane_q      <= lane_d;
      lanes_q     <= lanes_d;
      round_q     <= round_d;
      cont_q      <= cont_d;
      apply_q     <= apply_d;
      start_rep_q <= start_rep_d;
      cnt_q       <= cnt_d;
      tx_msg_q    <= tx_msg_d;
      valid_q     <= valid_d;
      end_q       <= end_d;
      err_q       <= err_d;
    end
  end

  assign sb.o_Start_Repeater                        = start_rep_q;
  assign sb.o_apply_repeater                        = apply_q;
  assign sb.o_TX_SbMessage                          = tx_msg_q;
  assign sb.o_ValidOutDatat_REPAIRMB_Module_Partner = valid_q;
  assign sb.o_Functional_Lanes                      = lanes_q;
  assign sb.o_degrade_round                         = round_q;
  assign sb.o_train_error                           = err_q;
  assign sb.o_MBINIT_REPAIRMB_Module_Partner_end    = end_q;

endmodule
